// File: rtl/trade_alert_synth.sv
// trade_alert_synth
// Turns matching-engine trade events into short stereo square-wave chirps
// for the WM8731 serial audio controller.
// A buy or sell event plays two notes separated by a silent gap: a low then
// high tone for a buy, and the reverse for a sell. A cancel plays a single
// low note. Each note starts at AMP_MAX, and the amplitude halves every
// DECAY_SAMPLES samples. One 16-bit signed sample pair is produced per audio
// frame and held stable until the next frame.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   evt_valid    trade event offered
//   evt_type     0=buy, 1=sell, 2=cancel, 3=reserved (accepted and dropped)
//   evt_ready    high while the 1-deep pending slot is empty
//   busy         high whenever a chirp (note or gap) is in progress
//   sample_tick  one-cycle strobe marking each sample boundary
//   left_data    signed left sample, updated the cycle after sample_tick
//   right_data   signed right sample, updated the cycle after sample_tick
module trade_alert_synth #(
   parameter int          CLK_PER_SAMPLE = 256,
   parameter int          NOTE_SAMPLES   = 9766,
   parameter int          GAP_SAMPLES    = 1953,
   parameter int          HALF_LO        = 195,
   parameter int          HALF_HI        = 98,
   parameter int          DECAY_SAMPLES  = 1024,
   parameter logic [15:0] AMP_MAX        = 16'h2000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               evt_valid,
   input  logic [1:0]         evt_type,
   output logic               evt_ready,
   output logic               busy,
   output logic               sample_tick,
   output logic signed [15:0] left_data,
   output logic signed [15:0] right_data
);

   localparam int TICK_W   = (CLK_PER_SAMPLE > 1) ? $clog2(CLK_PER_SAMPLE) : 1;
   localparam int CNT_MAX  = (NOTE_SAMPLES > GAP_SAMPLES) ? NOTE_SAMPLES : GAP_SAMPLES;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);
   localparam int HALF_MAX = (HALF_LO > HALF_HI) ? HALF_LO : HALF_HI;
   localparam int TONE_W   = $clog2(HALF_MAX + 1);

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_PER_SAMPLE - 1);
   localparam logic [CNT_W-1:0]  NOTE_LAST = CNT_W'(NOTE_SAMPLES - 1);
   localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_SAMPLES - 1);
   localparam logic [TONE_W-1:0] LO_LAST   = TONE_W'(HALF_LO - 1);
   localparam logic [TONE_W-1:0] HI_LAST   = TONE_W'(HALF_HI - 1);

   localparam logic [1:0] EVT_BUY    = 2'd0;
   localparam logic [1:0] EVT_SELL   = 2'd1;
   localparam logic [1:0] EVT_CANCEL = 2'd2;
   localparam logic [1:0] EVT_RSVD   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_NOTE_A = 2'd1,
      ST_GAP    = 2'd2,
      ST_NOTE_B = 2'd3
   } state_t;

   // Registers
   logic [TICK_W-1:0]  tick_cnt_r;
   logic               sample_tick_r;
   logic               pend_valid_r;
   logic [1:0]         pend_type_r;
   logic               evt_ready_r;
   state_t             state_r;
   logic [1:0]         type_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [TONE_W-1:0]  tone_r;
   logic               phase_r;
   logic               busy_r;
   logic signed [15:0] left_r;
   logic signed [15:0] right_r;

   // Combinational signals
   logic [TICK_W-1:0]  tick_nxt_s;
   logic               accept_s;
   logic               pop_s;
   logic               pend_valid_nxt_s;
   logic [1:0]         pend_type_nxt_s;
   logic [TONE_W-1:0]  half_last_s;
   logic [TONE_W-1:0]  tone_adv_s;
   logic               phase_adv_s;
   state_t             state_nxt_s;
   logic [1:0]         type_nxt_s;
   logic [CNT_W-1:0]   cnt_nxt_s;
   logic [TONE_W-1:0]  tone_nxt_s;
   logic               phase_nxt_s;
   logic [31:0]        shift_s;
   logic [15:0]        amp_s;
   logic signed [15:0] s_s;
   logic signed [15:0] s_half_s;
   logic signed [15:0] left_nxt_s;
   logic signed [15:0] right_nxt_s;

   assign evt_ready   = evt_ready_r;
   assign busy        = busy_r;
   assign sample_tick = sample_tick_r;
   assign left_data   = left_r;
   assign right_data  = right_r;

   assign accept_s = evt_valid && evt_ready_r;

   // Next value of the free-running sample-period counter.
   always_comb begin
      if (tick_cnt_r == TICK_LAST) begin
         tick_nxt_s = {TICK_W{1'b0}};
      end else begin
         tick_nxt_s = tick_cnt_r + TICK_W'(1'b1);
      end
   end

   // Sample-period counter; the strobe is registered so it is high exactly
   // while the counter holds its last value.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt_r    <= {TICK_W{1'b0}};
         sample_tick_r <= 1'b0;
      end else begin
         tick_cnt_r    <= tick_nxt_s;
         sample_tick_r <= (tick_nxt_s == TICK_LAST);
      end
   end

   // Pending slot update. Accept and pop never coincide because accept needs
   // an empty slot and pop needs a full one. Reserved events are taken off
   // the bus but never stored.
   always_comb begin
      pend_valid_nxt_s = pend_valid_r;
      pend_type_nxt_s  = pend_type_r;
      if (sample_tick_r && pop_s) begin
         pend_valid_nxt_s = 1'b0;
      end else if (accept_s && (evt_type != EVT_RSVD)) begin
         pend_valid_nxt_s = 1'b1;
         pend_type_nxt_s  = evt_type;
      end else begin
         pend_valid_nxt_s = pend_valid_r;
      end
   end

   // Pending slot register and the ready flag derived from its next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_valid_r <= 1'b0;
         pend_type_r  <= EVT_BUY;
         evt_ready_r  <= 1'b1;
      end else begin
         pend_valid_r <= pend_valid_nxt_s;
         pend_type_r  <= pend_type_nxt_s;
         evt_ready_r  <= !pend_valid_nxt_s;
      end
   end

   // Tone half-period for the current note and the advanced tone counter/phase.
   always_comb begin
      if (state_r == ST_NOTE_A) begin
         half_last_s = (type_r == EVT_SELL) ? HI_LAST : LO_LAST;
      end else begin
         half_last_s = (type_r == EVT_BUY) ? HI_LAST : LO_LAST;
      end
      if (tone_r == half_last_s) begin
         tone_adv_s  = {TONE_W{1'b0}};
         phase_adv_s = ~phase_r;
      end else begin
         tone_adv_s  = tone_r + TONE_W'(1'b1);
         phase_adv_s = phase_r;
      end
   end

   // FSM next state. The counters always describe the sample that is about
   // to be presented, so every new note starts with count 0, tone 0 and a
   // positive phase.
   always_comb begin
      state_nxt_s = state_r;
      type_nxt_s  = type_r;
      cnt_nxt_s   = cnt_r;
      tone_nxt_s  = tone_r;
      phase_nxt_s = phase_r;
      pop_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (pend_valid_r) begin
               pop_s       = 1'b1;
               state_nxt_s = ST_NOTE_A;
               type_nxt_s  = pend_type_r;
               cnt_nxt_s   = {CNT_W{1'b0}};
               tone_nxt_s  = {TONE_W{1'b0}};
               phase_nxt_s = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_NOTE_A: begin
            if (cnt_r == NOTE_LAST) begin
               state_nxt_s = (type_r == EVT_CANCEL) ? ST_IDLE : ST_GAP;
               cnt_nxt_s   = {CNT_W{1'b0}};
               tone_nxt_s  = {TONE_W{1'b0}};
               phase_nxt_s = 1'b1;
            end else begin
               cnt_nxt_s   = cnt_r + CNT_W'(1'b1);
               tone_nxt_s  = tone_adv_s;
               phase_nxt_s = phase_adv_s;
            end
         end
         ST_GAP: begin
            if (cnt_r == GAP_LAST) begin
               state_nxt_s = ST_NOTE_B;
               cnt_nxt_s   = {CNT_W{1'b0}};
               tone_nxt_s  = {TONE_W{1'b0}};
               phase_nxt_s = 1'b1;
            end else begin
               cnt_nxt_s   = cnt_r + CNT_W'(1'b1);
            end
         end
         ST_NOTE_B: begin
            if (cnt_r == NOTE_LAST) begin
               cnt_nxt_s   = {CNT_W{1'b0}};
               tone_nxt_s  = {TONE_W{1'b0}};
               phase_nxt_s = 1'b1;
               if (pend_valid_r) begin
                  // Chain straight into the queued chirp with no idle sample.
                  pop_s       = 1'b1;
                  state_nxt_s = ST_NOTE_A;
                  type_nxt_s  = pend_type_r;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end else begin
               cnt_nxt_s   = cnt_r + CNT_W'(1'b1);
               tone_nxt_s  = tone_adv_s;
               phase_nxt_s = phase_adv_s;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = {CNT_W{1'b0}};
            tone_nxt_s  = {TONE_W{1'b0}};
            phase_nxt_s = 1'b1;
         end
      endcase
   end

   // Sample value for the coming frame, computed from the next-state values
   // so the output lines up with the state it belongs to. Shifts of 16 or
   // more leave the amplitude at 0.
   always_comb begin
      shift_s  = 32'(cnt_nxt_s) / 32'(DECAY_SAMPLES);
      amp_s    = AMP_MAX >> shift_s;
      if (phase_nxt_s) begin
         s_s = signed'(amp_s);
      end else begin
         s_s = signed'(16'd0 - amp_s);
      end
      s_half_s    = s_s >>> 1;
      left_nxt_s  = 16'sd0;
      right_nxt_s = 16'sd0;
      if ((state_nxt_s == ST_NOTE_A) || (state_nxt_s == ST_NOTE_B)) begin
         case (type_nxt_s)
            EVT_BUY: begin
               left_nxt_s  = s_s;
               right_nxt_s = s_half_s;
            end
            EVT_SELL: begin
               left_nxt_s  = s_half_s;
               right_nxt_s = s_s;
            end
            EVT_CANCEL: begin
               left_nxt_s  = s_s;
               right_nxt_s = s_s;
            end
            default: begin
               left_nxt_s  = 16'sd0;
               right_nxt_s = 16'sd0;
            end
         endcase
      end else begin
         left_nxt_s  = 16'sd0;
         right_nxt_s = 16'sd0;
      end
   end

   // FSM state, counters and sample outputs; they advance only at sample ticks.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         type_r  <= EVT_BUY;
         cnt_r   <= {CNT_W{1'b0}};
         tone_r  <= {TONE_W{1'b0}};
         phase_r <= 1'b1;
         busy_r  <= 1'b0;
         left_r  <= 16'sd0;
         right_r <= 16'sd0;
      end else if (sample_tick_r) begin
         state_r <= state_nxt_s;
         type_r  <= type_nxt_s;
         cnt_r   <= cnt_nxt_s;
         tone_r  <= tone_nxt_s;
         phase_r <= phase_nxt_s;
         busy_r  <= (state_nxt_s != ST_IDLE);
         left_r  <= left_nxt_s;
         right_r <= right_nxt_s;
      end
   end

endmodule

// File: tb/tb_trade_alert_synth.sv
// Self-checking bench for trade_alert_synth using scaled-down parameters:
// 4 clocks per sample, 8-sample notes, 2-sample gap, tone half-periods of
// 2 and 1 samples, decay every 4 samples, amplitude 256.
module tb_trade_alert_synth;

   localparam logic [1:0] EVT_BUY    = 2'd0;
   localparam logic [1:0] EVT_SELL   = 2'd1;
   localparam logic [1:0] EVT_CANCEL = 2'd2;
   localparam logic [1:0] EVT_RSVD   = 2'd3;

   logic               clk = 1'b0;
   logic               rst;
   logic               evt_valid;
   logic [1:0]         evt_type;
   logic               evt_ready;
   logic               busy;
   logic               sample_tick;
   logic signed [15:0] left_data;
   logic signed [15:0] right_data;

   always #5 clk = ~clk;

   trade_alert_synth #(
      .CLK_PER_SAMPLE (4),
      .NOTE_SAMPLES   (8),
      .GAP_SAMPLES    (2),
      .HALF_LO        (2),
      .HALF_HI        (1),
      .DECAY_SAMPLES  (4),
      .AMP_MAX        (16'h0100)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .evt_valid   (evt_valid),
      .evt_type    (evt_type),
      .evt_ready   (evt_ready),
      .busy        (busy),
      .sample_tick (sample_tick),
      .left_data   (left_data),
      .right_data  (right_data)
   );

   typedef struct {
      logic               offer;
      logic [1:0]         etype;
      logic signed [15:0] exp_l;
      logic signed [15:0] exp_r;
      logic               exp_busy;
      logic               exp_ready;
   } vec_t;

   vec_t vecs[64];
   int   nvec    = 0;
   int   n_tests = 0;
   int   n_fail  = 0;

   // Low tone (half-period 2) and high tone (half-period 1) note shapes.
   int lo_pat[8] = '{256, 256, -256, -256, 128, 128, -128, -128};
   int hi_pat[8] = '{256, -256, 256, -256, 128, -128, 128, -128};
   logic [7:0] exp_tick = 8'b1000_1000;

   task automatic add_vec(input logic offer, input logic [1:0] et,
                          input int l, input int r, input logic b);
      vecs[nvec].offer     = offer;
      vecs[nvec].etype     = et;
      vecs[nvec].exp_l     = 16'(l);
      vecs[nvec].exp_r     = 16'(r);
      vecs[nvec].exp_busy  = b;
      vecs[nvec].exp_ready = 1'b1;
      nvec++;
   endtask

   task automatic check_val(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Advance to just after the next sample-tick edge.
   task automatic next_sample();
      int guard;
      guard = 0;
      @(negedge clk);
      while (!sample_tick && guard < 16) begin
         @(negedge clk);
         guard++;
      end
      if (!sample_tick) begin
         n_tests++;
         n_fail++;
         $display("FAIL tick_timeout: got no sample_tick, expected one within 16 cycles");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic offer_pulse(input logic [1:0] t);
      evt_type  = t;
      evt_valid = 1'b1;
      @(posedge clk);
      #1;
      evt_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, expected end within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      evt_valid = 1'b0;
      evt_type  = EVT_BUY;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state.
      check_val("rst_left",  int'(left_data),   0);
      check_val("rst_right", int'(right_data),  0);
      check_val("rst_ready", int'(evt_ready),   1);
      check_val("rst_busy",  int'(busy),        0);
      check_val("rst_tick",  int'(sample_tick), 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check_val($sformatf("tick_period_%0d", i), int'(sample_tick), int'(exp_tick[i]));
      end
      @(posedge clk);
      #1;

      // Vector table: buy, sell, cancel and reserved events from idle.
      for (int i = 0; i < 8; i++) add_vec(i == 0, EVT_BUY, lo_pat[i], lo_pat[i] / 2, 1'b1);
      for (int i = 0; i < 2; i++) add_vec(1'b0, EVT_BUY, 0, 0, 1'b1);
      for (int i = 0; i < 8; i++) add_vec(1'b0, EVT_BUY, hi_pat[i], hi_pat[i] / 2, 1'b1);
      add_vec(1'b0, EVT_BUY, 0, 0, 1'b0);
      for (int i = 0; i < 8; i++) add_vec(i == 0, EVT_SELL, hi_pat[i] / 2, hi_pat[i], 1'b1);
      for (int i = 0; i < 2; i++) add_vec(1'b0, EVT_SELL, 0, 0, 1'b1);
      for (int i = 0; i < 8; i++) add_vec(1'b0, EVT_SELL, lo_pat[i] / 2, lo_pat[i], 1'b1);
      add_vec(1'b0, EVT_SELL, 0, 0, 1'b0);
      for (int i = 0; i < 8; i++) add_vec(i == 0, EVT_CANCEL, lo_pat[i], lo_pat[i], 1'b1);
      add_vec(1'b0, EVT_CANCEL, 0, 0, 1'b0);
      add_vec(1'b1, EVT_RSVD, 0, 0, 1'b0);
      add_vec(1'b0, EVT_RSVD, 0, 0, 1'b0);

      for (int i = 0; i < nvec; i++) begin
         if (vecs[i].offer) offer_pulse(vecs[i].etype);
         next_sample();
         check_val($sformatf("vec%0d_left", i),  int'(left_data),  int'(vecs[i].exp_l));
         check_val($sformatf("vec%0d_right", i), int'(right_data), int'(vecs[i].exp_r));
         check_val($sformatf("vec%0d_busy", i),  int'(busy),       int'(vecs[i].exp_busy));
         check_val($sformatf("vec%0d_ready", i), int'(evt_ready),  int'(vecs[i].exp_ready));
      end

      // Back-to-back: buy playing, sell queued, cancel stalled at the producer.
      offer_pulse(EVT_BUY);
      next_sample();
      check_val("b2b_buy_first", int'(left_data), 256);
      offer_pulse(EVT_SELL);
      check_val("b2b_sell_accepted", int'(evt_ready), 0);
      evt_type  = EVT_CANCEL;
      evt_valid = 1'b1;
      for (int i = 1; i < 18; i++) begin
         next_sample();
         check_val($sformatf("b2b_stall_%0d", i), int'(evt_ready), 0);
      end
      check_val("b2b_buy_last", int'(left_data), -128);
      next_sample();
      check_val("b2b_sell_left",  int'(left_data),  128);
      check_val("b2b_sell_right", int'(right_data), 256);
      check_val("b2b_sell_busy",  int'(busy),       1);
      check_val("b2b_slot_freed", int'(evt_ready),  1);
      @(posedge clk);
      #1;
      evt_valid = 1'b0;
      check_val("b2b_cancel_accepted", int'(evt_ready), 0);
      for (int i = 1; i < 18; i++) next_sample();
      check_val("b2b_sell_last_left",  int'(left_data),  -64);
      check_val("b2b_sell_last_right", int'(right_data), -128);
      next_sample();
      check_val("b2b_cancel_left",  int'(left_data),  256);
      check_val("b2b_cancel_right", int'(right_data), 256);
      check_val("b2b_cancel_ready", int'(evt_ready),  1);
      for (int i = 1; i < 9; i++) next_sample();
      check_val("b2b_end_busy", int'(busy),      0);
      check_val("b2b_end_left", int'(left_data), 0);

      // Event accepted on the tick cycle itself starts at the following tick.
      begin
         int guard;
         guard = 0;
         @(negedge clk);
         while (!sample_tick && guard < 16) begin
            @(negedge clk);
            guard++;
         end
         check_val("ontick_found_tick", int'(sample_tick), 1);
      end
      evt_type  = EVT_BUY;
      evt_valid = 1'b1;
      @(posedge clk);
      #1;
      evt_valid = 1'b0;
      check_val("ontick_left_still_0", int'(left_data), 0);
      check_val("ontick_busy_still_0", int'(busy),      0);
      check_val("ontick_slot_full",    int'(evt_ready), 0);
      next_sample();
      check_val("ontick_first_left",  int'(left_data),  256);
      check_val("ontick_first_right", int'(right_data), 128);
      check_val("ontick_first_busy",  int'(busy),       1);

      // Reset during the gap with a queued cancel discards everything.
      offer_pulse(EVT_CANCEL);
      check_val("rstgap_slot_full", int'(evt_ready), 0);
      for (int i = 1; i < 9; i++) next_sample();
      check_val("rstgap_in_gap_left", int'(left_data), 0);
      check_val("rstgap_in_gap_busy", int'(busy),      1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_val("rstgap_left",  int'(left_data),  0);
      check_val("rstgap_right", int'(right_data), 0);
      check_val("rstgap_ready", int'(evt_ready),  1);
      check_val("rstgap_busy",  int'(busy),       0);
      rst = 1'b0;
      for (int i = 0; i < 24; i++) begin
         next_sample();
         check_val($sformatf("rstgap_quiet_left_%0d", i), int'(left_data), 0);
         check_val($sformatf("rstgap_quiet_busy_%0d", i), int'(busy),      0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/trade_alert_synth.md
Name: trade_alert_synth

Overview:
- Audio sample source that sits directly upstream of the WM8731 serial audio controller and drives its left_data/right_data inputs.
- Turns matching-engine trade events (buy fill, sell fill, cancel) into short stereo square-wave chirps with a stepped decay envelope.
- Produces one 16-bit signed sample pair per audio frame and holds it stable between frames.

Parameters:
- CLK_PER_SAMPLE, 256, clk cycles per sample; one serializer frame is 32 BCLK at clk/8.
- NOTE_SAMPLES, 9766, length of each note in samples (~50 ms).
- GAP_SAMPLES, 1953, silence between the two notes of a chirp, in samples.
- HALF_LO, 195, half-period of the low tone in samples (~500 Hz).
- HALF_HI, 98, half-period of the high tone in samples (~1 kHz).
- DECAY_SAMPLES, 1024, amplitude halves every DECAY_SAMPLES samples within a note.
- AMP_MAX, 16'h2000, initial positive amplitude of each note.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- evt_valid  in  1  trade event offered.
- evt_type  in  2  0=buy, 1=sell, 2=cancel, 3=reserved.
- evt_ready  out  1  high when the pending slot is empty.
- busy  out  1  high in any state other than IDLE.
- sample_tick  out  1  one-cycle strobe at each sample boundary.
- left_data  out  16  signed left sample.
- right_data  out  16  signed right sample.

Behaviour:
Reset:
- rst sampled high at a clk edge clears the following: tick counter to 0, FSM to IDLE, pending slot empty, all counters 0, left_data/right_data = 0, sample_tick = 0, busy = 0, evt_ready = 1.
- Reset mid-chirp aborts immediately. Output is 0 on the next cycle, and any pending event is discarded.

Tick:
- Free-running counter 0..CLK_PER_SAMPLE-1.
- sample_tick = 1 for exactly the cycle in which the counter equals CLK_PER_SAMPLE-1.
- All FSM, counter and output updates occur only on edges where sample_tick = 1. Sample outputs change the cycle after the tick and are otherwise held.

Handshake and pending slot:
- An event is accepted when evt_valid && evt_ready.
- The accepted type is stored in a 1-deep pending slot, and evt_ready drops the next cycle.
- evt_type 3 is accepted and dropped: no sound, and the slot stays empty.
- Acceptance coinciding with a tick in IDLE starts the event at the next tick, not the current one.

FSM (IDLE, NOTE_A, GAP, NOTE_B):
- IDLE: at a tick with the slot full, pop the slot, latch the type, and enter NOTE_A. Sample counter, tone counter and envelope are cleared; the square-wave phase is positive.
- NOTE_A: runs for NOTE_SAMPLES ticks.
  - Tone is HALF_LO for buy and cancel, HALF_HI for sell.
  - At the end: cancel goes to IDLE; buy and sell go to GAP.
- GAP: outputs 0 for GAP_SAMPLES ticks, then enters NOTE_B.
- NOTE_B: the opposite tone to NOTE_A (buy = HI, sell = LO), NOTE_SAMPLES ticks, then IDLE.
  - If the slot is full at the final tick, go directly to NOTE_A with the popped event. There are no idle samples between chirps.
- Back-to-back: while busy, one further event may be accepted into the slot. evt_ready stays low until it is popped, and later events stall at the producer.

Note sample generation:
- The square-wave phase toggles when the tone counter reaches half-1; the counter then wraps to 0.
- amp = AMP_MAX >> floor(note_cnt / DECAY_SAMPLES), saturating at 0 once shifted out.
- s = phase ? +amp : -amp, 16-bit two's complement. Negation of 0 is 0.

Stereo mapping:
- buy: left = s, right = s >>> 1.
- sell: left = s >>> 1, right = s.
- cancel: left = right = s.
- GAP and IDLE: both 0.

Test Plan:
Common setup for all scenarios: CLK_PER_SAMPLE=4, NOTE_SAMPLES=8, GAP_SAMPLES=2, HALF_LO=2, HALF_HI=1, DECAY_SAMPLES=4, AMP_MAX=16'h0100.
- Reset state: rst held high 3 cycles, then low → outputs 0, evt_ready=1, busy=0, and sample_tick pulses every 4th cycle.
- Buy chirp: one buy event →
  - NOTE_A left sequence +256,+256,-256,-256,+128,+128,-128,-128, with right at half those values;
  - then 2 zero samples;
  - then NOTE_B left +256,-256,+256,-256,+128,-128,+128,-128;
  - then 0 and busy=0.
- Sell and cancel:
  - Sell → right carries the full-amplitude sequence: HI tone first, then LO.
  - Cancel → equal channels, NOTE_A LO only, 8 samples, no gap.
- Back-to-back: buy accepted, then sell offered during NOTE_A →
  - sell accepted and evt_ready=0;
  - a third event is stalled until NOTE_B ends;
  - sell NOTE_A starts on the tick after buy's last NOTE_B sample.
- Boundary cases:
  - Event accepted on a tick cycle → first nonzero sample appears at the following tick.
  - evt_type=3 → no output and busy stays 0.
- Reset mid-operation: rst asserted during GAP with the slot full → next cycle outputs 0, evt_ready=1; no sound follows until a new event arrives.
